// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the decoder FSM state type used by byte_decode_stream.
package kyber_pkg;

  localparam int unsigned KYBER_Q = 3329;
  localparam int unsigned KYBER_N = 256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } decode_state_e;

endpackage

// File: rtl/decode_bit_acc.sv
// LSB-first bit accumulator: bytes are appended above the valid bits, D-bit
// coefficients are popped from the bottom; push and pop may share a cycle.
module decode_bit_acc #(
  parameter int D     = 12,
  parameter int ACC_W = D + 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [7:0]                   i_byte,
  input  logic                         i_pop,
  output logic [D-1:0]                 o_coeff,
  output logic [$clog2(ACC_W+1)-1:0]   o_cnt,
  output logic                         o_room
);

  localparam int CW = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [ACC_W-1:0] w_accAfter;
  logic [CW-1:0]    w_cntAfter;

  // The pop is applied first so a same-cycle push lands right above the survivors.
  always_comb begin
    w_accAfter = r_acc;
    w_cntAfter = r_cnt;
    if (i_pop) begin
      w_accAfter = r_acc >> D;
      w_cntAfter = r_cnt - CW'(D);
    end
  end

  assign o_room  = (32'(w_cntAfter) + 32'd8) <= 32'(ACC_W);
  assign o_coeff = r_acc[D-1:0];
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_acc <= w_accAfter | (ACC_W'(i_byte) << w_cntAfter);
      r_cnt <= w_cntAfter + CW'(8);
    end else begin
      r_acc <= w_accAfter;
      r_cnt <= w_cntAfter;
    end
  end

endmodule

// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_D: unpacks NUM_COEFFS*D/8 bytes into NUM_COEFFS D-bit coefficients.
// Optional macro DECODE_MODQ_CHK_EN adds a sticky err flag for coefficients >= KYBER_Q.
module byte_decode_stream
  import kyber_pkg::*;
#(
  parameter int D          = 12,
  parameter int NUM_COEFFS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [D-1:0] out_coeff,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_idx,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int ACC_W       = D + 7;
  localparam int CW          = $clog2(ACC_W + 1);
  localparam int TOTAL_BYTES = NUM_COEFFS * D / 8;
  localparam int BW          = $clog2(TOTAL_BYTES + 1);
  localparam int NW          = $clog2(NUM_COEFFS + 1);

  if (D < 1 || D > 12) begin : g_bad_d
    $error("byte_decode_stream: D=%0d outside legal range 1..12", D);
  end
  if (NUM_COEFFS % 8 != 0) begin : g_bad_n
    $error("byte_decode_stream: NUM_COEFFS=%0d is not a multiple of 8", NUM_COEFFS);
  end

  decode_state_e r_state, w_nextState;

  logic [BW-1:0] r_byteCount;
  logic [NW-1:0] r_coeffCount;
  logic [D-1:0]  r_outCoeff;
  logic          r_outValid;
  logic [7:0]    r_outIdx;

  logic [D-1:0]  w_coeff;
  logic [CW-1:0] w_cnt;
  logic          w_room;
  logic          w_push;
  logic          w_pop;
  logic          w_outFire;
  logic          w_last;
  logic          w_startAccepted;

  assign w_startAccepted = (r_state == IDLE) && start;
  assign w_outFire       = r_outValid && out_ready;
  assign w_last          = w_outFire && (r_coeffCount == NW'(NUM_COEFFS - 1));
  assign w_pop           = (r_state == RUN) && (w_cnt >= CW'(D)) && (!r_outValid || out_ready);
  assign in_ready        = (r_state == RUN) && (r_byteCount < BW'(TOTAL_BYTES)) && w_room;
  assign w_push          = in_valid && in_ready;

  decode_bit_acc #(
    .D     (D),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_byte  (in_byte),
    .i_pop   (w_pop),
    .o_coeff (w_coeff),
    .o_cnt   (w_cnt),
    .o_room  (w_room)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (w_last) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The output slot is refilled on the same edge it is drained, so a ready consumer sees one coefficient per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byteCount  <= '0;
      r_coeffCount <= '0;
      r_outCoeff   <= '0;
      r_outValid   <= 1'b0;
      r_outIdx     <= '0;
    end else begin
      if (w_startAccepted) begin
        r_byteCount  <= '0;
        r_coeffCount <= '0;
      end else begin
        if (w_push)    r_byteCount  <= r_byteCount + BW'(1);
        if (w_outFire) r_coeffCount <= r_coeffCount + NW'(1);
      end
      if (w_pop) begin
        r_outCoeff <= w_coeff;
        r_outValid <= 1'b1;
      end else if (w_outFire) begin
        r_outValid <= 1'b0;
      end
      if (w_last || w_startAccepted) r_outIdx <= '0;
      else if (w_outFire)            r_outIdx <= r_outIdx + 8'd1;
    end
  end

`ifdef DECODE_MODQ_CHK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       r_err <= 1'b0;
    else if (w_startAccepted)                       r_err <= 1'b0;
    else if (w_pop && (32'(w_coeff) >= KYBER_Q))    r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign out_coeff = r_outCoeff;
  assign out_valid = r_outValid;
  assign out_idx   = r_outIdx;
  assign done      = (r_state == DONE);
  assign busy      = (r_state == RUN);

endmodule
